// File: rtl/lif_scheduler.sv
// lif_scheduler: shares one leaky integrate-and-fire datapath across N_NEURONS 8-bit membranes.
// Latency: one neuron per clock; done pulses N+1 cycles after start, spike events 1 cycle after evaluation.
// Backpressure: none; start is ignored while busy, cfg_we/clr are honoured only in IDLE.
// Optional feature macro: LIF_SCHED_REFRACTORY_EN (per-neuron refractory counters, REFRACT_SWEEPS long).
module lif_scheduler #(
    parameter int N_NEURONS      = 8,
    parameter int IDX_W          = $clog2(N_NEURONS),
    parameter int REFRACT_SWEEPS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     cur_idx,
    input  logic [7:0]           cur_data,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_thr,
    input  logic [2:0]           cfg_leak,
    input  logic                 clr
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     fsm;
    logic [7:0] thr;
    logic [2:0] leak;
    logic [7:0] membrane [N_NEURONS];

    logic [7:0] leaked;
    logic [8:0] sum_w;
    logic [7:0] sum_sat;
    logic       fire;
    logic [7:0] next_mem;
    logic       last_idx;

`ifdef LIF_SCHED_REFRACTORY_EN
    localparam int RC_W = (REFRACT_SWEEPS < 1) ? 1 : $clog2(REFRACT_SWEEPS + 1);
    logic [RC_W-1:0] refr [N_NEURONS];
    logic            refr_active;
`endif

    assign last_idx = (cur_idx == IDX_W'(N_NEURONS - 1));

    // Shared LIF update for the neuron selected by cur_idx: leak, integrate with saturation, threshold.
    always_comb begin
        leaked   = membrane[cur_idx] >> leak;
        sum_w    = {1'b0, cur_data} + {1'b0, leaked};
        sum_sat  = sum_w[8] ? 8'hFF : sum_w[7:0];
        fire     = (sum_sat >= thr);
        next_mem = fire ? 8'h00 : sum_sat;
`ifdef LIF_SCHED_REFRACTORY_EN
        // A refractory neuron stays discharged and cannot fire, whatever its input.
        refr_active = (refr[cur_idx] != '0);
        if (refr_active) begin
            fire     = 1'b0;
            next_mem = 8'h00;
        end
`endif
    end

    // Sweep sequencer: IDLE -> SCAN (one neuron per cycle) -> DONE -> IDLE, plus config capture in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cur_idx <= '0;
            thr     <= 8'd32;
            leak    <= 3'd1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (cfg_we) begin
                        thr  <= cfg_thr;
                        leak <= cfg_leak;
                    end
                    // clr wins over start: the clear happens and no sweep begins.
                    if (start && !clr) begin
                        fsm     <= SCAN;
                        busy    <= 1'b1;
                        cur_idx <= '0;
                    end
                end
                SCAN: begin
                    if (last_idx) begin
                        fsm     <= DONE;
                        done    <= 1'b1;
                        cur_idx <= '0;
                    end else begin
                        cur_idx <= cur_idx + 1'b1;
                    end
                end
                DONE: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                default: begin
                    fsm     <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cur_idx <= '0;
                end
            endcase
        end
    end

    // Membrane/spike register file: written back during SCAN, wiped by clr in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                membrane[i] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
                refr[i] <= '0;
`endif
            end
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
        end else begin
            spike_valid <= 1'b0;
            if (fsm == IDLE && clr) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    membrane[i] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
                    refr[i] <= '0;
`endif
                end
                spike_vec <= '0;
            end else if (fsm == SCAN) begin
                membrane[cur_idx]  <= next_mem;
                spike_vec[cur_idx] <= fire;
                spike_valid        <= fire;
                if (fire) begin
                    spike_idx <= cur_idx;
                end
`ifdef LIF_SCHED_REFRACTORY_EN
                if (fire) begin
                    refr[cur_idx] <= RC_W'(REFRACT_SWEEPS);
                end else if (refr_active) begin
                    refr[cur_idx] <= refr[cur_idx] - 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
// Testbench for lif_scheduler: directed test-plan steps plus random sweeps against a sweep-level model.
module tb_lif_scheduler;

    localparam int N  = 8;
    localparam int IW = $clog2(N);
    localparam int RS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_we = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    cfg_thr = 8'd0;
    logic [2:0]    cfg_leak = 3'd0;
    logic [7:0]    cur_data;
    logic          busy, done, spike_valid;
    logic [IW-1:0] cur_idx, spike_idx;
    logic [N-1:0]  spike_vec;

    logic [7:0]    cur_tab [N];

    int checks = 0;
    int errors = 0;

    // Reference model: whole-sweep behaviour in plain integers.
    int       m_mem [N];
    int       m_rc  [N];
    int       m_thr;
    int       m_leak;
    logic [N-1:0] m_vec;
    bit       exp_fire [N];

    always #5 clk = ~clk;

    assign cur_data = cur_tab[cur_idx];

    lif_scheduler #(
        .N_NEURONS(N), .IDX_W(IW), .REFRACT_SWEEPS(RS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cur_idx(cur_idx), .cur_data(cur_data), .spike_valid(spike_valid),
        .spike_idx(spike_idx), .spike_vec(spike_vec), .cfg_we(cfg_we),
        .cfg_thr(cfg_thr), .cfg_leak(cfg_leak), .clr(clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_mem[k] = 0;
            m_rc[k]  = 0;
        end
        m_vec  = '0;
        m_thr  = 32;
        m_leak = 1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_mem[k] = 0;
            m_rc[k]  = 0;
        end
        m_vec = '0;
    endtask

    task automatic model_sweep();
        for (int k = 0; k < N; k++) begin
            int s;
            s = int'(cur_tab[k]) + (m_mem[k] >> m_leak);
            if (s > 255) s = 255;
`ifdef LIF_SCHED_REFRACTORY_EN
            if (m_rc[k] > 0) begin
                m_rc[k]     = m_rc[k] - 1;
                exp_fire[k] = 1'b0;
                m_mem[k]    = 0;
            end else begin
                exp_fire[k] = (s >= m_thr);
                m_mem[k]    = exp_fire[k] ? 0 : s;
                if (exp_fire[k]) m_rc[k] = RS;
            end
`else
            exp_fire[k] = (s >= m_thr);
            m_mem[k]    = exp_fire[k] ? 0 : s;
`endif
            m_vec[k] = exp_fire[k];
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_vec"}, spike_vec, m_vec);
        for (int k = 0; k < N; k++) chk({tag, "_mem"}, dut.membrane[k], m_mem[k]);
    endtask

    task automatic do_cfg(input int t, input int l);
        cfg_we = 1'b1; cfg_thr = t[7:0]; cfg_leak = l[2:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_thr = t; m_leak = l;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_clear();
    endtask

    // One full sweep with cycle-accurate checks; disturb pokes start/cfg_we during SCAN and DONE.
    task automatic run_sweep(input bit disturb);
        model_sweep();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            chk("busy", busy, 1);
            chk("cur_idx", cur_idx, (c <= N) ? c - 1 : 0);
            chk("done", done, (c == N + 1) ? 1 : 0);
            if (c >= 2) begin
                chk("spike_valid", spike_valid, exp_fire[c-2]);
                if (exp_fire[c-2]) chk("spike_idx", spike_idx, c - 2);
            end else begin
                chk("spike_valid0", spike_valid, 0);
            end
            if (disturb && (c == 3 || c == N + 1)) begin
                start = 1'b1; cfg_we = 1'b1; cfg_thr = 8'd100; cfg_leak = 3'd2;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; cfg_we = 1'b0;
        chk("busy_end", busy, 0);
        chk("done_end", done, 0);
        chk("spike_valid_end", spike_valid, 0);
        check_state("sweep");
    endtask

    initial begin
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sv", spike_valid, 0);
        chk("rst_sidx", spike_idx, 0);
        chk("rst_idx", cur_idx, 0);
        chk("rst_thr", dut.thr, 32);
        chk("rst_leak", dut.leak, 1);
        check_state("rst");

        // All currents 10: no spikes, all states 10.
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd10;
        run_sweep(1'b0);
        chk("c10_vec", spike_vec, 0);
        chk("c10_mem7", dut.membrane[7], 10);

        // clr beats start in the same IDLE cycle.
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        model_clear();
        chk("clr_busy", busy, 0);
        @(posedge clk); #1;
        chk("clr_busy2", busy, 0);
        check_state("clr");

        // Neuron 3 driven above threshold.
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd0;
        cur_tab[3] = 8'd40;
        run_sweep(1'b0);
        chk("n3_vec", spike_vec, 8'h08);
        chk("n3_mem", dut.membrane[3], 0);

        // Saturation; cfg_we with start in the same cycle is applied to that sweep.
        do_clr();
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd250;
        cfg_we = 1'b1; cfg_thr = 8'd255; cfg_leak = 3'd1;
        m_thr = 255; m_leak = 1;
        run_sweep(1'b0);
        chk("sat1_vec", spike_vec, 8'h00);
        chk("sat1_mem", dut.membrane[5], 250);
        run_sweep(1'b0);
        chk("sat2_vec", spike_vec, 8'hFF);

        // Config writes during SCAN/DONE are ignored, then honoured in IDLE.
        do_cfg(32, 1);
        for (int k = 0; k < N; k++) cur_tab[k] = 8'($urandom_range(0, 60));
        run_sweep(1'b1);
        chk("scan_cfg_thr", dut.thr, 32);
        chk("scan_cfg_leak", dut.leak, 1);
        do_cfg(100, 2);
        run_sweep(1'b0);
        chk("idle_cfg_thr", dut.thr, 100);
        chk("idle_cfg_leak", dut.leak, 2);

        // Asynchronous reset in the middle of a sweep.
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_idx", cur_idx, 4);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", busy, 0);
        chk("arst_idx", cur_idx, 0);
        chk("arst_done", done, 0);
        chk("arst_thr", dut.thr, 32);
        check_state("arst");
        #1 rst_n = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk); #1;
            chk("arst_no_done", done, 0);
        end
        run_sweep(1'b0);

        // Threshold zero: every neuron fires.
        do_cfg(0, 1);
        run_sweep(1'b0);
        chk("thr0_vec", spike_vec, 8'hFF);

        // Random sweeps with random configuration and occasional clears.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) cur_tab[k] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) do_cfg($urandom_range(0, 255), $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) do_clr();
            run_sweep(1'($urandom_range(0, 1)));
        end

        // Constant current on neuron 0: refractory spacing or every-sweep firing.
        do_clr();
        do_cfg(32, 1);
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd0;
        cur_tab[0] = 8'd40;
        for (int s = 1; s <= 7; s++) begin
            run_sweep(1'b0);
`ifdef LIF_SCHED_REFRACTORY_EN
            chk("refr_n0", spike_vec[0], ((s - 1) % 3 == 0) ? 1 : 0);
`else
            chk("consec_n0", spike_vec[0], 1);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
